picoblaze_led_pwm: RTL



---
 rtl/picoblaze_led_pwm.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/picoblaze_led_pwm.sv
// rtl/picoblaze_led_pwm.sv - PWM dimming and blink gate between the PicoBlaze LED register and the LED pins
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   port_id       PicoBlaze port address
//   write_strobe  PicoBlaze one-cycle write qualifier
//   out_port      PicoBlaze write data
//   led_pattern   latched LED pattern from the output register
//   led_out       registered LED pin drive (pattern gated by PWM and blink)
//   period_start  one-cycle pulse on the first clk of every PWM period

module picoblaze_led_pwm #(
  parameter int unsigned  PRESCALE     = 196,
  parameter logic [7:0]   DUTY_PORT_ID = 8'h01,
  parameter logic [7:0]   MODE_PORT_ID = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  input  logic [7:0] led_pattern,
  output logic [7:0] led_out,
  output logic       period_start
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt;
  logic        tick;
  logic [7:0]  pwm_cnt;
  logic        period_end;

  logic        duty_wr;
  logic        mode_wr;
  logic [7:0]  duty_shadow;
  logic [7:0]  duty_active;

  logic [2:0]  mode_q;
  logic        blink_en;
  logic [6:0]  blink_half_m1;
  logic [6:0]  blink_cnt;
  logic        blink_phase;

  logic        pwm_on;

  // Prescaler and PWM ramp
  assign tick       = (pre_cnt == PRE_MAX);
  assign period_end = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

  // Port decode
  assign duty_wr = write_strobe && (port_id == DUTY_PORT_ID);
  assign mode_wr = write_strobe && (port_id == MODE_PORT_ID);

  // Duty is double-buffered so a write only takes effect at a period
  // boundary. A write landing exactly on period_end bypasses the shadow so
  // the firmware does not lose a whole period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_shadow <= 8'hFF;
      duty_active <= 8'hFF;
    end else begin
      if (duty_wr) begin
        duty_shadow <= out_port;
      end
      if (period_end) begin
        duty_active <= duty_wr ? out_port : duty_shadow;
      end
    end
  end

  // Mode register: only bits [2:0] are stored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= '0;
    end else if (mode_wr) begin
      mode_q <= out_port[2:0];
    end
  end

  assign blink_en = mode_q[0];

  // Half-period length in PWM periods, minus one: 16/32/64/128
  always_comb begin
    blink_half_m1 = 7'd15;
    case (mode_q[2:1])
      2'd0: blink_half_m1 = 7'd15;
      2'd1: blink_half_m1 = 7'd31;
      2'd2: blink_half_m1 = 7'd63;
      2'd3: blink_half_m1 = 7'd127;
      default: blink_half_m1 = 7'd15;
    endcase
  end

  // Blink envelope. A mode write restarts the envelope in the "on" phase,
  // and it has priority over a coincident period_end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (mode_wr || !blink_en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (period_end) begin
      if (blink_cnt == blink_half_m1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 7'd1;
      end
    end
  end

  // 0xFF is special-cased so full brightness is truly constant rather than
  // 255/256.
  assign pwm_on = (duty_active == 8'hFF) ? 1'b1 : (pwm_cnt < duty_active);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out      <= 8'h00;
      period_start <= 1'b0;
    end else begin
      led_out      <= led_pattern & {8{pwm_on & blink_phase}};
      period_start <= period_end;
    end
  end

endmodule
